// File: rtl/cachepkg.sv
// ---------------------------------------------------------------------------
// cachepkg
// Shared types for the cache command arbiter.
//   op_t        : cache command carried from requesters to the cache
//   arb_state_t : arbiter FSM state encoding
//   is_urgent() : commands that let port 0 bypass round-robin order
// ---------------------------------------------------------------------------
package cachepkg;

  typedef enum logic [1:0] {
    NOP        = 2'd0,
    RESET      = 2'd1,
    INVALIDATE = 2'd2,
    INST_FETCH = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Maintenance commands must not sit behind instruction fetches.
  function automatic logic is_urgent(input op_t op);
    return (op == RESET) || (op == INVALIDATE);
  endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// ---------------------------------------------------------------------------
// cache_rr_pick
// Combinational round-robin selector: returns the first active request at or
// after the pointer, wrapping from REQS-1 back to 0.
// Ports:
//   req     in  REQS  active requests
//   pointer in  PTRW  index that currently has highest priority
//   winner  out REQS  one-hot winner (all zero when no request is active)
// ---------------------------------------------------------------------------
module cache_rr_pick #(
  parameter int REQS = 2,
  parameter int PTRW = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic [REQS-1:0] req,
  input  logic [PTRW-1:0] pointer,
  output logic [REQS-1:0] winner
);

  int              w_idx;
  logic            w_found;
  logic [PTRW-1:0] w_sel;

  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int i = 0; i < REQS; i++) begin
      // Candidate i positions after the pointer, wrapped without a divider.
      w_idx = int'(pointer) + i;
      if (w_idx >= REQS) begin
        w_idx = w_idx - REQS;
      end
      w_sel = PTRW'(w_idx);
      if (!w_found && req[w_sel]) begin
        winner[w_sel] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Arbitrates REQS requester ports onto a single cache command channel.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> RELEASE -> IDLE.
// Port 0 issuing RESET/INVALIDATE wins outright; otherwise round-robin.
// Optional feature macro: CACHE_ARB_TIMEOUT_EN adds a WAIT-state watchdog
// that aborts after TIMEOUT cycles and flags err_out alongside done_out.
// Ports:
//   clock, reset_n          clock / asynchronous active-low reset
//   req, op_in, addr_in     per-port request, command, address
//   gnt                     one-hot grant, held from grant until release
//   done_out                one-cycle completion pulse to granted port
//   err_out                 one-cycle pulse on watchdog abort
//   cache_op/addr/valid     command channel to cache (NOP/0 when idle)
//   cache_done              cache completion, honoured in ISSUE/WAIT only
//   busy                    high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module cache_arbiter
  import cachepkg::*;
#(
  parameter int REQS     = 2,
  parameter int ADDRBITS = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [REQS-1:0]               req,
  input  op_t  [REQS-1:0]               op_in,
  input  logic [REQS-1:0][ADDRBITS-1:0] addr_in,
  output logic [REQS-1:0]               gnt,
  output logic [REQS-1:0]               done_out,
  output logic                          err_out,
  output op_t                           cache_op,
  output logic [ADDRBITS-1:0]           cache_addr,
  output logic                          cache_valid,
  input  logic                          cache_done,
  output logic                          busy
);

  localparam int              PTRW     = (REQS > 1) ? $clog2(REQS) : 1;
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(REQS - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cache_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [REQS-1:0]       r_gnt;
  op_t                   r_op;
  logic [ADDRBITS-1:0]   r_addr;
  logic [PTRW-1:0]       r_ptr;
  logic [PTRW-1:0]       r_win_idx;

  logic [REQS-1:0]       w_rr_win;
  logic [REQS-1:0]       w_win;
  logic [PTRW-1:0]       w_win_idx;
  logic                  w_urgent;
  logic                  w_grant;
  logic                  w_timeout;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  cache_rr_pick #(
    .REQS (REQS),
    .PTRW (PTRW)
  ) u_rr_pick (
    .req     (req),
    .pointer (r_ptr),
    .winner  (w_rr_win)
  );

  assign w_urgent = req[0] && is_urgent(op_in[0]);
  assign w_win    = w_urgent ? REQS'(1) : w_rr_win;
  assign w_grant  = (r_state == IDLE) && (|req);

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < REQS; i++) begin
      if (w_win[i]) begin
        w_win_idx = PTRW'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional watchdog
  // -------------------------------------------------------------------------
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int             WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] r_wdog;
  logic           r_tmo;

  // Fires on the last allowed WAIT cycle; a same-cycle cache_done still wins.
  assign w_timeout = (r_state == WAIT) && !cache_done && (r_wdog == WD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      // r_tmo is only ever high during the RELEASE that a timeout caused.
      r_tmo <= w_timeout;
      if (r_state == WAIT) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign err_out = (r_state == RELEASE) && r_tmo;
`else
  assign w_timeout = 1'b0;
  assign err_out   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and command-channel outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    cache_valid  = 1'b0;
    cache_op     = NOP;
    cache_addr   = '0;
    done_out     = '0;
    busy         = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        // A NOP is granted and completed without touching the cache.
        if (r_op != NOP) begin
          cache_valid = 1'b1;
          cache_op    = r_op;
          cache_addr  = r_addr;
        end
        if ((r_op == NOP) || cache_done) begin
          w_state_next = RELEASE;
        end else begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (cache_done || w_timeout) begin
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        done_out     = r_gnt;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant, latched command and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt     <= '0;
      r_op      <= NOP;
      r_addr    <= '0;
      r_ptr     <= '0;
      r_win_idx <= '0;
    end else if (w_grant) begin
      // Command is captured here so later input changes cannot disturb it.
      r_gnt     <= w_win;
      r_op      <= op_in[w_win_idx];
      r_addr    <= addr_in[w_win_idx];
      r_win_idx <= w_win_idx;
    end else if (r_state == RELEASE) begin
      r_gnt <= '0;
      r_ptr <= (r_win_idx == LAST_IDX) ? '0 : r_win_idx + 1'b1;
    end
  end

  assign gnt = r_gnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Directed bench for cache_arbiter (REQS=2, ADDRBITS=32, TIMEOUT=64).
// Build with CACHE_ARB_TIMEOUT_EN defined to exercise the watchdog path.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;
  import cachepkg::*;

  logic             clock;
  logic             reset_n;
  logic [1:0]       req;
  op_t  [1:0]       op_in;
  logic [1:0][31:0] addr_in;
  logic [1:0]       gnt;
  logic [1:0]       done_out;
  logic             err_out;
  op_t              cache_op;
  logic [31:0]      cache_addr;
  logic             cache_valid;
  logic             cache_done;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  cache_arbiter #(
    .REQS     (2),
    .ADDRBITS (32),
    .TIMEOUT  (64)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .op_in       (op_in),
    .addr_in     (addr_in),
    .gnt         (gnt),
    .done_out    (done_out),
    .err_out     (err_out),
    .cache_op    (cache_op),
    .cache_addr  (cache_addr),
    .cache_valid (cache_valid),
    .cache_done  (cache_done),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/gnt"},   gnt,         64'd0);
    chk({tag, "/busy"},  busy,        64'd0);
    chk({tag, "/done"},  done_out,    64'd0);
    chk({tag, "/err"},   err_out,     64'd0);
    chk({tag, "/valid"}, cache_valid, 64'd0);
    chk({tag, "/op"},    cache_op,    64'(NOP));
    chk({tag, "/addr"},  cache_addr,  64'd0);
  endtask

  // Called in an IDLE cycle with the request(s) already driven. Steps through
  // the whole transaction of 'port'; nwait = WAIT cycles before cache_done
  // (0 means cache_done in the ISSUE cycle). Drops req[port] on done_out.
  task automatic txn(input string tag, input int port, input op_t op,
                     input logic [31:0] addr, input int nwait);
    logic [63:0] pm;
    pm = 64'd1 << port;
    step();
    chk({tag, "/issue_gnt"},  gnt,  pm);
    chk({tag, "/issue_busy"}, busy, 64'd1);
    if (op == NOP) begin
      chk({tag, "/issue_valid"}, cache_valid, 64'd0);
      chk({tag, "/issue_op"},    cache_op,    64'(NOP));
    end else begin
      chk({tag, "/issue_valid"}, cache_valid, 64'd1);
      chk({tag, "/issue_op"},    cache_op,    64'(op));
      chk({tag, "/issue_addr"},  cache_addr,  64'(addr));
    end
    // Disturb the granted port's inputs; the latched command must not move.
    addr_in[port] = ~addr_in[port];
    op_in[port]   = NOP;
    if (op != NOP) begin
      if (nwait == 0) cache_done = 1'b1;
      for (int w = 1; w <= nwait; w++) begin
        step();
        chk({tag, "/wait_valid"}, cache_valid, 64'd0);
        chk({tag, "/wait_op"},    cache_op,    64'(NOP));
        chk({tag, "/wait_gnt"},   gnt,         pm);
        chk({tag, "/wait_done"},  done_out,    64'd0);
        cache_done = (w == nwait);
      end
    end
    step();
    cache_done = 1'b0;
    chk({tag, "/rel_done"},  done_out,    pm);
    chk({tag, "/rel_gnt"},   gnt,         pm);
    chk({tag, "/rel_err"},   err_out,     64'd0);
    chk({tag, "/rel_valid"}, cache_valid, 64'd0);
    req[port] = 1'b0;
    step();
    chk_quiet({tag, "/idle"});
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = '0;
    op_in[0]   = NOP;
    op_in[1]   = NOP;
    addr_in    = '0;
    cache_done = 1'b0;

    // Reset state
    step();
    step();
    chk_quiet("reset");
    reset_n = 1'b1;
    step();

    // Single fetch on port 1: ISSUE + 3 WAIT + RELEASE = 5 grant cycles
    req[1] = 1'b1; op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_1040;
    txn("fetch1", 1, INST_FETCH, 32'h0000_1040, 3);

    // Contention with pointer 0: port 0 then port 1
    req = 2'b11;
    op_in[0] = INST_FETCH; addr_in[0] = 32'h0000_0100;
    op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0200;
    txn("contA_p0", 0, INST_FETCH, 32'h0000_0100, 1);
    txn("contA_p1", 1, INST_FETCH, 32'h0000_0200, 0);

    // NOP on port 0: completes without cache_valid; pointer moves to 1
    req[0] = 1'b1; op_in[0] = NOP; addr_in[0] = 32'h0000_0055;
    txn("nop_p0", 0, NOP, 32'h0, 0);

    // Contention with pointer 1: port 1 first
    req = 2'b11;
    op_in[0] = INST_FETCH; addr_in[0] = 32'h0000_0300;
    op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0400;
    txn("contB_p1", 1, INST_FETCH, 32'h0000_0400, 2);
    txn("contB_p0", 0, INST_FETCH, 32'h0000_0300, 0);

    // Pointer is 1, but port 0 INVALIDATE overrides round-robin
    req = 2'b11;
    op_in[0] = INVALIDATE; addr_in[0] = 32'h0000_0500;
    op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0600;
    txn("urg_p0", 0, INVALIDATE, 32'h0000_0500, 2);
    txn("urg_p1", 1, INST_FETCH, 32'h0000_0600, 0);

    // Port 0 RESET alone, leaves pointer at 1
    req[0] = 1'b1; op_in[0] = RESET; addr_in[0] = 32'h0000_0700;
    txn("rst_op_p0", 0, RESET, 32'h0000_0700, 1);

    // Reset mid-WAIT
    req[1] = 1'b1; op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0800;
    step();
    chk("midrst/issue_gnt", gnt, 64'd2);
    step();
    step();
    chk("midrst/wait_busy", busy, 64'd1);
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk_quiet("midrst/async");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("midrst/after");
    end

    // Pointer back to 0 after reset: port 0 wins contention
    req = 2'b11;
    op_in[0] = INST_FETCH; addr_in[0] = 32'h0000_0900;
    op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0A00;
    txn("ptr0_p0", 0, INST_FETCH, 32'h0000_0900, 0);
    txn("ptr0_p1", 1, INST_FETCH, 32'h0000_0A00, 1);

    // cache_done outside ISSUE/WAIT must be ignored
    cache_done = 1'b1;
    step();
    chk_quiet("stray_done");
    cache_done = 1'b0;

    // Cache never answers
    req[1] = 1'b1; op_in[1] = INST_FETCH; addr_in[1] = 32'h0000_0B00;
    step();
    chk("tmo/issue_valid", cache_valid, 64'd1);
    step();
`ifdef CACHE_ARB_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      chk("tmo/wait_gnt",  gnt,      64'd2);
      chk("tmo/wait_done", done_out, 64'd0);
      chk("tmo/wait_err",  err_out,  64'd0);
      step();
    end
    chk("tmo/rel_err",  err_out,  64'd1);
    chk("tmo/rel_done", done_out, 64'd2);
    req[1] = 1'b0;
    step();
    chk_quiet("tmo/idle");
`else
    for (int k = 1; k <= 150; k++) begin
      chk("hold/gnt",  gnt,      64'd2);
      chk("hold/done", done_out, 64'd0);
      chk("hold/err",  err_out,  64'd0);
      step();
    end
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk_quiet("hold/reset");
    step();
    reset_n = 1'b1;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
